rename_map_ckpt: RTL and testbench

//  Multi-lane register rename map: NLANE instructions/clk. Each source maps to the youngest in-flight

---
 rtl/rename_map_ckpt.sv | 225 ++++++++++++++++++++++
 tb/tb_rename_map_ckpt.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: multi-lane register rename map with branch checkpoints.
//
// Each group of up to NLANE instructions is renamed per clock. A source maps to the youngest
// in-flight commit slot producing it (earlier lane in the same group first, then the map), or to
// the architectural register itself. Branch lanes snapshot the map for 1-clk recovery; a flush
// without a checkpoint falls back to a 2-clk full reload (RELOAD1, RELOAD2).
//
// Tag format: bit RA-1 set = commit-slot tag {1, slot}, clear = architectural reg {0, r}.
//
// Optional feature macro: RENAME_FP_EN (undefined by default). When defined, LA=6 and NARCH=64,
// and in_rd[5] selects the FP file. FP f0 is renamed normally; only integer x0 is pinned to {0,0}.
// RA widens so that a 6-bit architectural index still fits below the tag flag bit.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid[NLANE]               lane valid, packed from lane 0
//   in_rs1/2/3, in_rd [NLANE*LA]  source / destination arch regs per lane
//   in_makes_rd[NLANE]            lane writes in_rd
//   in_ckpt[NLANE]                lane is a branch needing a checkpoint (at most one per group)
//   alloc_base[LNCOMMIT]          commit slot of lane 0; lane i uses alloc_base+i mod NCOMMIT
//   commit_done[NCOMMIT]          slots retired this clock
//   flush, flush_ckpt, flush_ckpt_v  recovery request, checkpoint to restore, restore valid
//   ckpt_release                  oldest checkpoint freed
//   out_valid, out_rs1/2/3, out_ckpt_id  registered rename results
//   rename_stall                  group not accepted (checkpoints full)
//   rename_reloading              full reload in progress
module rename_map_ckpt #(
    parameter int unsigned NLANE    = 4,
    parameter int unsigned NCOMMIT  = 32,
    parameter int unsigned LNCOMMIT = 5,
    parameter int unsigned NCKPT    = 4,
`ifdef RENAME_FP_EN
    parameter int unsigned LA       = 6,
`else
    parameter int unsigned LA       = 5,
`endif
    parameter int unsigned RA       = ((LNCOMMIT > LA) ? LNCOMMIT : LA) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NLANE-1:0]           in_valid,
    input  logic [NLANE*LA-1:0]        in_rs1,
    input  logic [NLANE*LA-1:0]        in_rs2,
    input  logic [NLANE*LA-1:0]        in_rs3,
    input  logic [NLANE*LA-1:0]        in_rd,
    input  logic [NLANE-1:0]           in_makes_rd,
    input  logic [NLANE-1:0]           in_ckpt,
    input  logic [LNCOMMIT-1:0]        alloc_base,
    input  logic [NCOMMIT-1:0]         commit_done,
    input  logic                       flush,
    input  logic [$clog2(NCKPT)-1:0]   flush_ckpt,
    input  logic                       flush_ckpt_v,
    input  logic                       ckpt_release,
    output logic [NLANE-1:0]           out_valid,
    output logic [NLANE*RA-1:0]        out_rs1,
    output logic [NLANE*RA-1:0]        out_rs2,
    output logic [NLANE*RA-1:0]        out_rs3,
    output logic [$clog2(NCKPT)-1:0]   out_ckpt_id,
    output logic                       rename_stall,
    output logic                       rename_reloading
);
    localparam int unsigned NARCH = 1 << LA;
    localparam int unsigned LCKPT = $clog2(NCKPT);
    localparam int unsigned TW    = RA - 1;

    typedef enum logic [1:0] {StRun, StReload1, StReload2} state_e;

    state_e              r_state;
    logic                r_reloading;
    logic [RA-1:0]       r_map  [NARCH];
    logic [RA-1:0]       r_snap [NCKPT][NARCH];
    logic [LCKPT-1:0]    r_head, r_tail;
    logic [LCKPT:0]      r_count;
    logic [NLANE-1:0]    r_out_valid;
    logic [NLANE*RA-1:0] r_out_rs1, r_out_rs2, r_out_rs3;
    logic [LCKPT-1:0]    r_out_ckpt_id;

    logic [NLANE-1:0]    w_wr_en;
    logic [LNCOMMIT-1:0] w_slot [NLANE];
    logic [LA-1:0]       w_rd   [NLANE];
    logic [LA-1:0]       w_src  [NLANE][3];
    logic [RA-1:0]       w_tag  [NLANE][3];
    logic [RA-1:0]       w_map_clean [NARCH];
    logic [RA-1:0]       w_map_d     [NARCH];
    logic [RA-1:0]       w_snap_new  [NARCH];
    logic [RA-1:0]       w_restore   [NARCH];
    logic [RA-1:0]       w_snap_clean [NCKPT][NARCH];
    int unsigned         w_ckpt_lane;
    logic                w_any_ckpt, w_full, w_accept, w_take, w_release;
    logic [LCKPT-1:0]    w_head_n;

    function automatic logic [RA-1:0] f_arch(input int unsigned r);
        return {1'b0, TW'(r)};
    endfunction

    // A slot tag whose slot retires this clock falls back to the architectural register.
    function automatic logic [RA-1:0] f_clean(input logic [RA-1:0] tag,
                                              input logic [RA-1:0] arch,
                                              input logic [NCOMMIT-1:0] done);
        if (tag[RA-1] && done[tag[LNCOMMIT-1:0]]) return arch;
        return tag;
    endfunction

    always_comb begin
        w_ckpt_lane = NLANE;
        for (int unsigned i = 0; i < NLANE; i++) begin
            w_rd[i]     = in_rd[i*LA +: LA];
            w_src[i][0] = in_rs1[i*LA +: LA];
            w_src[i][1] = in_rs2[i*LA +: LA];
            w_src[i][2] = in_rs3[i*LA +: LA];
            w_slot[i]   = LNCOMMIT'((int'(alloc_base) + i) % NCOMMIT);
            w_wr_en[i]  = in_valid[i] & in_makes_rd[i] & (w_rd[i] != '0);
            if (in_valid[i] && in_ckpt[i] && w_ckpt_lane == NLANE) w_ckpt_lane = i;
        end
    end

    // Source lookup: older lanes of the same group bypass the map.
    always_comb begin : lookup
        logic [RA-1:0] t;
        for (int unsigned j = 0; j < NLANE; j++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                t = r_map[w_src[j][k]];
                for (int unsigned i = 0; i < NLANE; i++) begin
                    if (i < j && w_wr_en[i] && w_rd[i] == w_src[j][k]) begin
                        t = {1'b1, TW'(w_slot[i])};
                    end
                end
                t = f_clean(t, {1'b0, TW'(w_src[j][k])}, commit_done);
                if (w_src[j][k] == '0) t = '0;
                w_tag[j][k] = t;
            end
        end
    end

    // Next map: commit clear first, then lane writes in order so the highest lane wins.
    always_comb begin
        for (int unsigned r = 0; r < NARCH; r++) begin
            w_map_clean[r] = f_clean(r_map[r], f_arch(r), commit_done);
            w_restore[r]   = f_clean(r_snap[flush_ckpt][r], f_arch(r), commit_done);
            for (int unsigned n = 0; n < NCKPT; n++) begin
                w_snap_clean[n][r] = f_clean(r_snap[n][r], f_arch(r), commit_done);
            end
        end
        w_map_d    = w_map_clean;
        w_snap_new = w_map_clean;
        for (int unsigned i = 0; i < NLANE; i++) begin
            if (w_wr_en[i]) w_map_d[w_rd[i]] = {1'b1, TW'(w_slot[i])};
            if (i == w_ckpt_lane) w_snap_new = w_map_d;
        end
    end

    assign w_any_ckpt   = |(in_valid & in_ckpt);
    assign w_full       = (r_count == (LCKPT+1)'(NCKPT));
    assign rename_stall = w_full & w_any_ckpt;
    assign w_accept     = (r_state == StRun) & ~flush & ~rename_stall & (|in_valid);
    assign w_take       = w_accept & w_any_ckpt;
    assign w_release    = ckpt_release & (r_count != '0);
    assign w_head_n     = r_head + LCKPT'(w_release);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StRun;
            r_reloading   <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_out_valid   <= '0;
            r_out_rs1     <= '0;
            r_out_rs2     <= '0;
            r_out_rs3     <= '0;
            r_out_ckpt_id <= '0;
            for (int unsigned r = 0; r < NARCH; r++) begin
                r_map[r] <= f_arch(r);
                for (int unsigned n = 0; n < NCKPT; n++) r_snap[n][r] <= f_arch(r);
            end
        end else begin
            r_snap <= w_snap_clean;
            if (w_take) r_snap[r_tail] <= w_snap_new;
            r_out_valid   <= '0;
            r_out_ckpt_id <= '0;
            if (flush && (r_state != StRun || !flush_ckpt_v)) begin
                for (int unsigned r = 0; r < NARCH; r++) r_map[r] <= f_arch(r);
                r_head      <= r_tail;
                r_count     <= '0;
                r_state     <= StReload1;
                r_reloading <= 1'b1;
            end else if (flush) begin
                r_map   <= w_restore;
                r_head  <= w_head_n;
                r_tail  <= flush_ckpt + LCKPT'(1);
                r_count <= {1'b0, LCKPT'(flush_ckpt + LCKPT'(1) - w_head_n)};
            end else begin
                r_map   <= w_accept ? w_map_d : w_map_clean;
                r_head  <= w_head_n;
                r_tail  <= r_tail + LCKPT'(w_take);
                r_count <= r_count + (LCKPT+1)'(w_take) - (LCKPT+1)'(w_release);
                unique case (r_state)
                    StReload1: r_state <= StReload2;
                    StReload2: begin
                        r_state     <= StRun;
                        r_reloading <= 1'b0;
                    end
                    default:   r_state <= StRun;
                endcase
                if (w_accept) begin
                    r_out_valid <= in_valid;
                    for (int unsigned j = 0; j < NLANE; j++) begin
                        r_out_rs1[j*RA +: RA] <= w_tag[j][0];
                        r_out_rs2[j*RA +: RA] <= w_tag[j][1];
                        r_out_rs3[j*RA +: RA] <= w_tag[j][2];
                    end
                    if (w_take) r_out_ckpt_id <= r_tail;
                end
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign out_rs1          = r_out_rs1;
    assign out_rs2          = r_out_rs2;
    assign out_rs3          = r_out_rs3;
    assign out_ckpt_id      = r_out_ckpt_id;
    assign rename_reloading = r_reloading;

endmodule

// File: tb/tb_rename_map_ckpt.sv
module tb_rename_map_ckpt;
    localparam int NLANE    = 4;
    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = 5;
    localparam int NCKPT    = 4;
    localparam int LCK      = 2;
`ifdef RENAME_FP_EN
    localparam int LA       = 6;
`else
    localparam int LA       = 5;
`endif
    localparam int RA       = ((LNCOMMIT > LA) ? LNCOMMIT : LA) + 1;
    localparam int TW       = RA - 1;
    localparam int NARCH    = 1 << LA;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NLANE-1:0]     in_valid, in_makes_rd, in_ckpt;
    logic [NLANE*LA-1:0]  in_rs1, in_rs2, in_rs3, in_rd;
    logic [LNCOMMIT-1:0]  alloc_base;
    logic [NCOMMIT-1:0]   commit_done;
    logic                 flush, flush_ckpt_v, ckpt_release;
    logic [LCK-1:0]       flush_ckpt;
    logic [NLANE-1:0]     out_valid;
    logic [NLANE*RA-1:0]  out_rs1, out_rs2, out_rs3;
    logic [LCK-1:0]       out_ckpt_id;
    logic                 rename_stall, rename_reloading;

    rename_map_ckpt u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .in_rs3           (in_rs3),
        .in_rd            (in_rd),
        .in_makes_rd      (in_makes_rd),
        .in_ckpt          (in_ckpt),
        .alloc_base       (alloc_base),
        .commit_done      (commit_done),
        .flush            (flush),
        .flush_ckpt       (flush_ckpt),
        .flush_ckpt_v     (flush_ckpt_v),
        .ckpt_release     (ckpt_release),
        .out_valid        (out_valid),
        .out_rs1          (out_rs1),
        .out_rs2          (out_rs2),
        .out_rs3          (out_rs3),
        .out_ckpt_id      (out_ckpt_id),
        .rename_stall     (rename_stall),
        .rename_reloading (rename_reloading)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Stimulus for the current group
    bit        b_valid[NLANE], b_mk[NLANE], b_ck[NLANE];
    int        b_rs[NLANE][3], b_rd[NLANE];
    int        b_alloc, b_fc;
    bit [31:0] b_done;
    bit        b_flush, b_fv, b_rel;

    // Reference model: producer slot per arch reg (-1 = architectural), checkpoint ring.
    int prod[NARCH];
    int snap[NCKPT][NARCH];
    int head, tail, cnt, mst, nxt_alloc;

    function automatic int arch_tag(input int r);
        return r;
    endfunction

    function automatic int slot_tag(input int p);
        return (1 << TW) + p;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NARCH; r++) begin
            prod[r] = -1;
            for (int n = 0; n < NCKPT; n++) snap[n][r] = -1;
        end
        head = 0; tail = 0; cnt = 0; mst = 0; nxt_alloc = 0;
    endtask

    task automatic clr();
        for (int i = 0; i < NLANE; i++) begin
            b_valid[i] = 0; b_mk[i] = 0; b_ck[i] = 0; b_rd[i] = 0;
            for (int k = 0; k < 3; k++) b_rs[i][k] = 0;
        end
        b_alloc = nxt_alloc; b_done = 0; b_flush = 0; b_fv = 0; b_fc = 0; b_rel = 0;
    endtask

    function automatic int get_tag(input int j, input int k);
        logic [NLANE*RA-1:0] v;
        v = (k == 0) ? out_rs1 : (k == 1) ? out_rs2 : out_rs3;
        return int'(v[j*RA +: RA]);
    endfunction

    // Drive the group, check stall, advance the model, then check registered outputs.
    task automatic tick();
        bit any_ck, stall, accept, took, relv, wr;
        int ck_lane, nv, p, s, e_ckid;
        int e_tag[NLANE][3];
        bit e_valid[NLANE];
        for (int i = 0; i < NLANE; i++) begin
            in_valid[i]    = b_valid[i];
            in_makes_rd[i] = b_mk[i];
            in_ckpt[i]     = b_ck[i];
            in_rd[i*LA +: LA]  = LA'(b_rd[i]);
            in_rs1[i*LA +: LA] = LA'(b_rs[i][0]);
            in_rs2[i*LA +: LA] = LA'(b_rs[i][1]);
            in_rs3[i*LA +: LA] = LA'(b_rs[i][2]);
        end
        alloc_base = LNCOMMIT'(b_alloc); commit_done = b_done;
        flush = b_flush; flush_ckpt_v = b_fv; flush_ckpt = LCK'(b_fc); ckpt_release = b_rel;
        #1;
        any_ck = 0; ck_lane = -1; nv = 0;
        for (int i = 0; i < NLANE; i++) begin
            if (b_valid[i]) nv++;
            if (b_valid[i] && b_ck[i] && ck_lane < 0) begin any_ck = 1; ck_lane = i; end
        end
        stall = (cnt == NCKPT) && any_ck;
        check("stall", 32'(rename_stall), 32'(stall));
        accept = (mst == 0) && !b_flush && !stall && (nv > 0);
        for (int j = 0; j < NLANE; j++) begin
            e_valid[j] = accept && b_valid[j];
            for (int k = 0; k < 3; k++) begin
                s = b_rs[j][k];
                p = prod[s];
                for (int i = 0; i < j; i++)
                    if (b_valid[i] && b_mk[i] && b_rd[i] != 0 && b_rd[i] == s)
                        p = (b_alloc + i) % NCOMMIT;
                if (p >= 0 && b_done[p]) p = -1;
                e_tag[j][k] = (s == 0) ? 0 : (p < 0) ? arch_tag(s) : slot_tag(p);
            end
        end
        for (int r = 0; r < NARCH; r++) begin
            if (prod[r] >= 0 && b_done[prod[r]]) prod[r] = -1;
            for (int n = 0; n < NCKPT; n++)
                if (snap[n][r] >= 0 && b_done[snap[n][r]]) snap[n][r] = -1;
        end
        took = 0; e_ckid = 0;
        if (b_flush && (mst != 0 || !b_fv)) begin
            for (int r = 0; r < NARCH; r++) prod[r] = -1;
            head = tail; cnt = 0; mst = 1;
        end else if (b_flush) begin
            for (int r = 0; r < NARCH; r++) prod[r] = snap[b_fc][r];
            if (b_rel && cnt > 0) head = (head + 1) % NCKPT;
            tail = (b_fc + 1) % NCKPT;
            cnt = (tail - head + NCKPT) % NCKPT;
        end else begin
            if (accept) begin
                for (int i = 0; i < NLANE; i++) begin
                    wr = b_valid[i] && b_mk[i] && b_rd[i] != 0;
                    if (wr) prod[b_rd[i]] = (b_alloc + i) % NCOMMIT;
                    if (i == ck_lane) begin
                        for (int r = 0; r < NARCH; r++) snap[tail][r] = prod[r];
                        e_ckid = tail; tail = (tail + 1) % NCKPT; took = 1;
                    end
                end
                nxt_alloc = (b_alloc + nv) % NCOMMIT;
            end
            relv = b_rel && cnt > 0;
            if (relv) head = (head + 1) % NCKPT;
            cnt = cnt + int'(took) - int'(relv);
            if (mst == 1) mst = 2;
            else if (mst == 2) mst = 0;
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < NLANE; j++) begin
            check($sformatf("valid%0d", j), 32'(out_valid[j]), 32'(e_valid[j]));
            if (e_valid[j])
                for (int k = 0; k < 3; k++)
                    check($sformatf("lane%0d_rs%0d", j, k + 1), get_tag(j, k), e_tag[j][k]);
        end
        check("reloading", 32'(rename_reloading), 32'(mst != 0));
        if (took) check("ckpt_id", 32'(out_ckpt_id), e_ckid);
        @(negedge clk);
    endtask

    task automatic rand_group();
        int n, s;
        clr();
        n = $urandom_range(0, NLANE);
        for (int i = 0; i < NLANE; i++) begin
            b_valid[i] = (i < n);
            b_rd[i]    = $urandom_range(0, 7);
            b_mk[i]    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 3; k++)
                b_rs[i][k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NARCH - 1)
                                                          : $urandom_range(0, 7);
        end
        if (n > 0 && $urandom_range(0, 2) == 0) b_ck[$urandom_range(0, n - 1)] = 1;
        // Never retire a slot that is being allocated in the same clock.
        repeat (2) begin
            s = $urandom_range(0, NCOMMIT - 1);
            if ((s - b_alloc + NCOMMIT) % NCOMMIT >= NLANE) b_done[s] = 1;
        end
        b_flush = ($urandom_range(0, 24) == 0);
        b_fv    = b_flush && mst == 0 && cnt > 0 && ($urandom_range(0, 2) != 0);
        b_fc    = b_fv ? (head + $urandom_range(0, cnt - 1)) % NCKPT : 0;
        b_rel   = !b_fv && ($urandom_range(0, 3) == 0);
    endtask

    int x_slot;

    initial begin
        model_reset();
        clr();
        tick_inputs_zero();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_rs1", 32'(out_rs1), 0);
        check("rst_ckpt_id", 32'(out_ckpt_id), 0);
        check("rst_reloading", 32'(rename_reloading), 0);
        check("rst_stall", 32'(rename_stall), 0);
        reset_n = 1'b1;

        // Same-group bypass and wraparound of alloc_base
        clr(); b_alloc = 30;
        for (int i = 0; i < NLANE; i++) b_valid[i] = 1;
        b_rd[0] = 3; b_mk[0] = 1; b_rs[1][0] = 3; b_rd[3] = 3; b_mk[3] = 1;
        tick();
        check("bypass_tag", get_tag(1, 0), slot_tag(30));
        clr(); b_valid[0] = 1; b_rs[0][0] = 3;
        tick();
        check("highest_lane_wins", get_tag(0, 0), slot_tag(1));

        // Commit clear in the lookup clock; same-clock rename keeps the new tag
        clr(); b_valid[0] = 1; b_rd[0] = 7; b_mk[0] = 1; x_slot = b_alloc;
        tick();
        clr(); b_valid[0] = 1; b_rs[0][0] = 7; b_rd[0] = 7; b_mk[0] = 1; b_done[x_slot] = 1;
        x_slot = b_alloc;
        tick();
        check("commit_clear_lookup", get_tag(0, 0), arch_tag(7));
        clr(); b_valid[0] = 1; b_rs[0][0] = 7;
        tick();
        check("rename_beats_clear", get_tag(0, 0), slot_tag(x_slot));

        // Fill all checkpoints, stall, then release
        for (int n = 0; n < NCKPT; n++) begin
            clr(); b_valid[0] = 1; b_ck[0] = 1;
            tick();
        end
        clr(); b_valid[0] = 1; b_ck[0] = 1; b_rel = 1;
        tick();
        check("full_drop", 32'(out_valid), 0);
        clr(); b_valid[0] = 1; b_ck[0] = 1;
        tick();
        check("reuse_old_head", 32'(out_ckpt_id), 0);

        // Full reload
        clr(); b_flush = 1;
        tick();
        check("reload_clk1", 32'(rename_reloading), 1);
        clr(); b_valid[0] = 1; b_rs[0][0] = 3;
        tick();
        check("reload_drop", 32'(out_valid), 0);
        clr();
        tick();
        check("reload_done", 32'(rename_reloading), 0);
        clr(); b_valid[0] = 1; b_rs[0][0] = 3;
        tick();
        check("after_reload", get_tag(0, 0), arch_tag(3));

        // Checkpoint restore brings back the snapshotted producer of x9
        clr(); b_valid[0] = 1; b_rd[0] = 9; b_mk[0] = 1; x_slot = b_alloc;
        tick();
        clr(); b_valid[0] = 1; b_ck[0] = 1; b_fc = tail;
        tick();
        begin
            int fc;
            fc = b_fc;
            clr(); b_valid[0] = 1; b_rd[0] = 9; b_mk[0] = 1;
            tick();
            clr(); b_flush = 1; b_fv = 1; b_fc = fc;
            tick();
        end
        clr(); b_valid[0] = 1; b_rs[0][0] = 9;
        tick();
        check("ckpt_restore", get_tag(0, 0), slot_tag(x_slot));

        repeat (1500) begin
            rand_group();
            tick();
        end

        // Asynchronous reset in the middle of a group
        rand_group();
        tick_inputs_drive_only();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_reloading", 32'(rename_reloading), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        clr(); b_valid[0] = 1; b_rs[0][0] = 5;
        tick();
        check("midrst_next", get_tag(0, 0), arch_tag(5));

        repeat (300) begin
            rand_group();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic tick_inputs_zero();
        in_valid = '0; in_makes_rd = '0; in_ckpt = '0;
        in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_rd = '0;
        alloc_base = '0; commit_done = '0;
        flush = 1'b0; flush_ckpt_v = 1'b0; flush_ckpt = '0; ckpt_release = 1'b0;
    endtask

    task automatic tick_inputs_drive_only();
        for (int i = 0; i < NLANE; i++) begin
            in_valid[i] = b_valid[i];
            in_rs1[i*LA +: LA] = LA'(b_rs[i][0]);
        end
    endtask

endmodule
